// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for a 5-stage RISC-V pipeline: stage enables and bubble flushes.
// Latency: enables/flushes are Mealy (same cycle as inputs); counters and timeout are registered.
// Backpressure: a data-memory wait freezes every stage until mem_ack; load-use holds PC and IF/ID.
module hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT     = 256,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      id_inst_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             mem_wb_flush_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o
);

  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;

  // Control vector: {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush}
  localparam logic [6:0]  CTL_RUN     = 7'b1111_000;
  localparam logic [6:0]  CTL_BR      = 7'b1111_110;
  localparam logic [6:0]  CTL_LU      = 7'b0011_010;
  localparam logic [6:0]  CTL_FRZ     = 7'b0000_001;
  localparam logic [3:0]  LU_REM_INIT = 4'(LU_STALL_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d, ret_state_q, ret_state_d, eff_state;
  logic [3:0]       lu_rem_q, lu_rem_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic [6:0]       ctl;
  logic             flush_inc;
  logic             use_rs1, use_rs2, lu_hazard, mem_stall;
  logic             unused_inst_bits;

  assign unused_inst_bits = ^{id_inst_i[31:25], id_inst_i[14:7]};

  // Source-register usage decode and hazard detection
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_inst_i[6:0])
      7'b0000011, 7'b0010011: use_rs1 = 1'b1;
      7'b0100011, 7'b1100011, 7'b0110011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
    lu_hazard = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                ((use_rs1 && (ex_rd_i == id_inst_i[19:15])) ||
                 (use_rs2 && (ex_rd_i == id_inst_i[24:20])));
    mem_stall = mem_req_i && !mem_ack_i;
  end

  // Priority-ordered control and next-state evaluation
  always_comb begin
    state_d       = state_q;
    ret_state_d   = ret_state_q;
    lu_rem_d      = lu_rem_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    flush_inc     = 1'b0;
    ctl           = CTL_RUN;
    // On the ack cycle the stalled state resumes with its own rules.
    eff_state     = (state_q == MEM_WAIT) ? ret_state_q : state_q;
    if ((state_q != MEM_WAIT) && mem_stall) begin
      ctl         = CTL_FRZ;
      ret_state_d = state_q;
      wait_cnt_d  = 16'd1;
      state_d     = MEM_WAIT;
    end else if ((state_q == MEM_WAIT) && !mem_ack_i) begin
      ctl = CTL_FRZ;
      if (wait_cnt_q != 16'hFFFF) begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        if (wait_cnt_d == TIMEOUT_VAL) mem_timeout_d = 1'b1;
      end
    end else begin
      state_d = eff_state;
      if (eff_state == LU_STALL) begin
        // A bubble sits in EX, so a taken-branch indication here is meaningless.
        ctl      = CTL_LU;
        lu_rem_d = lu_rem_q - 4'd1;
        if (lu_rem_q <= 4'd1) state_d = RUN;
      end else if (ex_branch_taken_i) begin
        ctl       = CTL_BR;
        flush_inc = 1'b1;
      end else if (lu_hazard) begin
        ctl = CTL_LU;
        if (LU_STALL_CYCLES > 1) begin
          lu_rem_d = LU_REM_INIT;
          state_d  = LU_STALL;
        end
      end
    end
  end

  // FSM state, wait counter and sticky timeout
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      ret_state_q   <= RUN;
      lu_rem_q      <= 4'd0;
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_state_q   <= ret_state_d;
      lu_rem_q      <= lu_rem_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Saturating stall and squash counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!ctl[6] && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != CNT_MAX)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  // While in reset every register is held and loaded with a bubble.
  assign pc_en_o        = rst_ni & ctl[6];
  assign if_id_en_o     = rst_ni & ctl[5];
  assign id_ex_en_o     = rst_ni & ctl[4];
  assign ex_mem_en_o    = rst_ni & ctl[3];
  assign if_id_flush_o  = ~rst_ni | ctl[2];
  assign id_ex_flush_o  = ~rst_ni | ctl[1];
  assign mem_wb_flush_o = ~rst_ni | ctl[0];
  assign mem_timeout_o  = mem_timeout_q;
  assign stall_count_o  = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: three parameterisations share one stimulus stream.
// Each cycle compares controls, counters and timeout against a behavioural model.
// Directed test-plan scenarios first, then randomized traffic with occasional async resets.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] id_inst = 32'h0;
  logic        ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
  logic [4:0]  ex_rd = 5'd0;

  logic [2:0]  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush, tmo;
  logic [31:0] sc0, sc1, fc0, fc1;
  logic [3:0]  sc2, fc2;

  int n_tests = 0;
  int n_fail  = 0;

  // Model parameters per instance
  int LU[3] = '{1, 3, 2};
  int MT[3] = '{256, 4, 5};
  int CW[3] = '{32, 32, 4};

  // Behavioural model state: bubbles still owed, waiting flag, wait length, sticky flag, counters
  int     bub[3];
  bit     wt[3];
  int     wc[3];
  bit     to_m[3];
  longint scm[3], fcm[3];

  localparam logic [31:0] ADD = 32'h0052_8333;
  localparam logic [31:0] LUI = 32'h0000_52B7;
  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  hazard_ctrl #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(256), .CNT_W(32)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .id_inst_i(id_inst), .ex_mem_read_i(ex_mem_read),
    .ex_rd_i(ex_rd), .ex_branch_taken_i(ex_branch_taken), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
    .pc_en_o(pc_en[0]), .if_id_en_o(if_id_en[0]), .id_ex_en_o(id_ex_en[0]), .ex_mem_en_o(ex_mem_en[0]),
    .if_id_flush_o(if_id_flush[0]), .id_ex_flush_o(id_ex_flush[0]), .mem_wb_flush_o(mem_wb_flush[0]),
    .mem_timeout_o(tmo[0]), .stall_count_o(sc0), .flush_count_o(fc0));

  hazard_ctrl #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(32)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .id_inst_i(id_inst), .ex_mem_read_i(ex_mem_read),
    .ex_rd_i(ex_rd), .ex_branch_taken_i(ex_branch_taken), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
    .pc_en_o(pc_en[1]), .if_id_en_o(if_id_en[1]), .id_ex_en_o(id_ex_en[1]), .ex_mem_en_o(ex_mem_en[1]),
    .if_id_flush_o(if_id_flush[1]), .id_ex_flush_o(id_ex_flush[1]), .mem_wb_flush_o(mem_wb_flush[1]),
    .mem_timeout_o(tmo[1]), .stall_count_o(sc1), .flush_count_o(fc1));

  hazard_ctrl #(.LU_STALL_CYCLES(2), .MEM_TIMEOUT(5), .CNT_W(4)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .id_inst_i(id_inst), .ex_mem_read_i(ex_mem_read),
    .ex_rd_i(ex_rd), .ex_branch_taken_i(ex_branch_taken), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
    .pc_en_o(pc_en[2]), .if_id_en_o(if_id_en[2]), .id_ex_en_o(id_ex_en[2]), .ex_mem_en_o(ex_mem_en[2]),
    .if_id_flush_o(if_id_flush[2]), .id_ex_flush_o(id_ex_flush[2]), .mem_wb_flush_o(mem_wb_flush[2]),
    .mem_timeout_o(tmo[2]), .stall_count_o(sc2), .flush_count_o(fc2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] ctl_of(int k);
    return {pc_en[k], if_id_en[k], id_ex_en[k], ex_mem_en[k],
            if_id_flush[k], id_ex_flush[k], mem_wb_flush[k]};
  endfunction

  function automatic logic [63:0] sc_of(int k);
    case (k)
      0:       return {32'h0, sc0};
      1:       return {32'h0, sc1};
      default: return {60'h0, sc2};
    endcase
  endfunction

  function automatic logic [63:0] fc_of(int k);
    case (k)
      0:       return {32'h0, fc0};
      1:       return {32'h0, fc1};
      default: return {60'h0, fc2};
    endcase
  endfunction

  function automatic longint sat_inc(longint v, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v >= mx) ? mx : v + 1;
  endfunction

  // Does the instruction in ID read the register an in-flight load writes?
  function automatic bit needs_loaded_reg(logic [31:0] ins, logic rd_load, logic [4:0] rd);
    int srcs[$];
    case (ins[6:0])
      7'h03, 7'h13:        srcs = '{int'(ins[19:15])};
      7'h23, 7'h63, 7'h33: srcs = '{int'(ins[19:15]), int'(ins[24:20])};
      default:             srcs = '{};
    endcase
    if (!rd_load || rd == 5'd0) return 1'b0;
    foreach (srcs[i]) if (srcs[i] == int'(rd)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      bub[k] = 0; wt[k] = 1'b0; wc[k] = 0; to_m[k] = 1'b0; scm[k] = 0; fcm[k] = 0;
    end
  endtask

  // Compare this cycle's outputs, then advance the model past the coming clock edge.
  task automatic model_check();
    bit haz;
    haz = needs_loaded_reg(id_inst, ex_mem_read, ex_rd);
    for (int k = 0; k < 3; k++) begin
      logic [6:0] e;
      chk($sformatf("u%0d.stall_count", k), sc_of(k), 64'(scm[k]));
      chk($sformatf("u%0d.flush_count", k), fc_of(k), 64'(fcm[k]));
      chk($sformatf("u%0d.mem_timeout", k), {63'h0, tmo[k]}, {63'h0, to_m[k]});
      if (!wt[k] && mem_req && !mem_ack) begin
        e = 7'b0000_001; wt[k] = 1'b1; wc[k] = 1;
      end else if (wt[k] && !mem_ack) begin
        e = 7'b0000_001;
        if (wc[k] < 65535) begin
          wc[k]++;
          if (wc[k] == MT[k]) to_m[k] = 1'b1;
        end
      end else begin
        wt[k] = 1'b0;
        if (bub[k] > 0) begin
          e = 7'b0011_010; bub[k]--;
        end else if (ex_branch_taken) begin
          e = 7'b1111_110; fcm[k] = sat_inc(fcm[k], CW[k]);
        end else if (haz) begin
          e = 7'b0011_010; bub[k] = LU[k] - 1;
        end else begin
          e = 7'b1111_000;
        end
      end
      chk($sformatf("u%0d.ctl", k), {57'h0, ctl_of(k)}, {57'h0, e});
      if (!e[6]) scm[k] = sat_inc(scm[k], CW[k]);
    end
  endtask

  task automatic cyc(input logic [31:0] ins, input logic mr, input logic [4:0] rd,
                     input logic br, input logic rq, input logic ak);
    id_inst = ins; ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br; mem_req = rq; mem_ack = ak;
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  // Async reset asserted mid-cycle; released just after the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.rst_ctl", k), {57'h0, ctl_of(k)}, 64'h07);
      chk($sformatf("u%0d.rst_sc", k), sc_of(k), 64'h0);
      chk($sformatf("u%0d.rst_fc", k), fc_of(k), 64'h0);
      chk($sformatf("u%0d.rst_to", k), {63'h0, tmo[k]}, 64'h0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops[8];
    ops = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h33, 7'h37, 7'h6F, 7'h73};
    return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            3'($urandom), 5'($urandom), ops[$urandom_range(0, 7)]};
  endfunction

  initial begin
    model_reset();
    do_reset();

    // Load-use, single bubble
    cyc(ADD, 1, 5, 0, 0, 0);
    cyc(NOP, 0, 0, 0, 0, 0);
    chk("lu.u0_stall_count", {32'h0, sc0}, 64'd1);
    chk("lu.u0_pc_en", {63'h0, pc_en[0]}, 64'd1);

    // rd=x0 and non-reading opcode: no stall
    do_reset();
    cyc(ADD, 1, 0, 0, 0, 0);
    cyc(LUI, 1, 5, 0, 0, 0);
    cyc(NOP, 0, 0, 0, 0, 0);
    chk("filt.u0_stall_count", {32'h0, sc0}, 64'd0);

    // Branch wins over a simultaneous hazard
    do_reset();
    cyc(ADD, 1, 5, 1, 0, 0);
    cyc(NOP, 0, 0, 0, 0, 0);
    chk("br.u0_flush_count", {32'h0, fc0}, 64'd1);
    chk("br.u1_stall_count", {32'h0, sc1}, 64'd0);

    // Three-cycle memory wait
    do_reset();
    repeat (3) cyc(NOP, 0, 0, 0, 1, 0);
    cyc(NOP, 0, 0, 0, 1, 1);
    cyc(NOP, 0, 0, 0, 0, 0);
    chk("mw.u0_stall_count", {32'h0, sc0}, 64'd3);

    // Memory wait landing in the second of three load-use bubbles
    do_reset();
    cyc(ADD, 1, 5, 0, 0, 0);
    cyc(NOP, 0, 0, 0, 1, 0);
    cyc(NOP, 0, 0, 0, 1, 0);
    cyc(NOP, 0, 0, 0, 1, 1);
    cyc(NOP, 0, 0, 0, 0, 0);
    cyc(NOP, 0, 0, 0, 0, 0);
    chk("lumw.u1_stall_count", {32'h0, sc1}, 64'd5);

    // Timeout with MEM_TIMEOUT=4, then async reset clears it
    do_reset();
    repeat (6) cyc(NOP, 0, 0, 0, 1, 0);
    chk("to.u1_timeout", {63'h0, tmo[1]}, 64'd1);
    do_reset();
    chk("to.u1_cleared", {63'h0, tmo[1]}, 64'd0);

    // Long wait to reach the default 256-cycle timeout on u0
    repeat (262) cyc(NOP, 0, 0, 0, 1, 0);
    chk("to.u0_timeout", {63'h0, tmo[0]}, 64'd1);
    cyc(NOP, 0, 0, 0, 1, 1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc(rand_inst(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 30),
            1'($urandom_range(0, 99) < 50));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It watches the instruction in ID, the load and branch status in EX, and the data-memory handshake in MEM. It drives the per-stage enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It sequences load-use stalls, branch-taken squashes and multi-cycle data-memory waits, and keeps saturating performance counters and a sticky timeout flag.

## Interface
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15)
- MEM_TIMEOUT, 256, MEM_WAIT cycles before mem_timeout sets (2..65535)
- CNT_W, 32, width of stall_count / flush_count
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- id_inst  in  32  instruction currently in ID
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_req  in  1  MEM stage has a valid load/store
- mem_ack  in  1  data memory completes the access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register write enables
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (NOP) into that register
- mem_timeout  out  1  sticky: a MEM_WAIT reached MEM_TIMEOUT cycles
- stall_count  out  CNT_W  cycles with pc_en=0 (saturating)
- flush_count  out  CNT_W  branch squashes (saturating)

## Operation
- Source-use decode from id_inst[6:0]:
  - rs1 (id_inst[19:15]) is used for 0000011, 0010011, 0100011, 1100011, 0110011.
  - rs2 (id_inst[24:20]) is used for 0100011, 1100011, 0110011.
  - Other opcodes use no sources.
- lu_hazard = ex_mem_read & ex_rd≠0 & ex_rd matches a used source.
- mem_stall = mem_req & ~mem_ack.
- States: RUN, LU_STALL, MEM_WAIT. Registers: lu_rem (4b), wait_cnt (16b), ret_state.
- Outputs are Mealy: state plus current inputs. Evaluate in priority order; first match wins.
- Any state except MEM_WAIT with mem_stall:
  - All four enables 0, mem_wb_flush=1, other flushes 0.
  - ret_state ← current state; wait_cnt ← 1; go MEM_WAIT.
- RUN, ex_branch_taken:
  - All enables 1, if_id_flush=1, id_ex_flush=1.
  - flush_count++; lu_hazard is ignored.
- RUN, lu_hazard:
  - pc_en=0, if_id_en=0, id_ex_en=1, ex_mem_en=1, id_ex_flush=1.
  - If LU_STALL_CYCLES>1: lu_rem ← LU_STALL_CYCLES−1; go LU_STALL.
- RUN, otherwise: all enables 1, all flushes 0.
- LU_STALL: same outputs as RUN lu_hazard, independent of lu_hazard. ex_branch_taken is ignored because a bubble is in EX. lu_rem−−; when lu_rem=1, go RUN.
- MEM_WAIT, mem_ack=0:
  - Freeze outputs as on entry.
  - wait_cnt++, saturating. When wait_cnt reaches MEM_TIMEOUT, mem_timeout ← 1.
- MEM_WAIT, mem_ack=1:
  - Outputs are computed by ret_state's rules with mem_stall treated as 0.
  - Next state is ret_state, with its own transition applied, e.g. LU_STALL with lu_rem=1 → RUN.
- stall_count increments every cycle pc_en=0 outside reset. Both counters saturate at 2^CNT_W−1.

## Timing
- Reset asserted (async):
  - state=RUN, lu_rem=0, wait_cnt=0, counters=0, mem_timeout=0.
  - Outputs forced: all enables 0, all flushes 1.
- Reset release: normal evaluation from the first clk edge.
- Reset mid-stall or mid-wait: aborts immediately. There is no resume.
- Load-use costs exactly LU_STALL_CYCLES cycles with pc_en=0. The dependent instruction leaves ID on the following cycle.
- Branch squash is zero-latency: flushes are asserted in the same cycle ex_branch_taken is seen in RUN.
- A branch held in EX during MEM_WAIT is applied on the mem_ack cycle.
- A mem_ack-cycle stall cannot re-enter MEM_WAIT. A new request is evaluated next cycle.
- mem_timeout only sets, and sets in the cycle wait_cnt reaches MEM_TIMEOUT. Only reset clears it. The core keeps waiting after the timeout.

## Test plan
- Load-use:
  - Stimulus: ex_mem_read=1, ex_rd=5, id_inst=0x00528333 (add x6,x5,x5), LU_STALL_CYCLES=1.
  - Response: one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_count=1; then RUN.
- rd=x0 and opcode filter:
  - Stimulus (a): ex_rd=0 with a matching source. Stimulus (b): id_inst=0x000052B7 (lui) with ex_rd=5.
  - Response: no stall in either case; all enables 1.
- Branch over hazard:
  - Stimulus: ex_branch_taken=1 and lu_hazard=1 together.
  - Response: if_id_flush=id_ex_flush=1, pc_en=1; flush_count=1; stall_count unchanged.
- Memory wait:
  - Stimulus: mem_req=1, mem_ack low for 3 cycles, then high.
  - Response: 3 cycles with all enables 0 and mem_wb_flush=1, then resume; stall_count=3.
- Wait interrupting a stall:
  - Stimulus: LU_STALL_CYCLES=3; mem_stall starts in the 2nd stall cycle and lasts 2 cycles.
  - Response: return to LU_STALL; total pc_en=0 cycles = 5.
- Timeout and reset:
  - Stimulus: MEM_TIMEOUT=4, mem_ack held low.
  - Response: mem_timeout rises in the 4th MEM_WAIT cycle and stays high. Asserting reset clears it and the counters asynchronously, with all flushes 1.
